// File: rtl/jigsaw_mmio_pkg.sv
// Shared types and constants for the jigsaw MMIO request sequencer.
package jigsaw_mmio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } jig_state_e;

    localparam logic JIG_OP_WR = 1'b1;
    localparam logic JIG_OP_RD = 1'b0;

    localparam int JIG_DEFAULT_TIMEOUT = 65536;

endpackage

// File: rtl/jigsaw_rr_arb2.sv
// Two-input round-robin arbiter. The last-grant pointer starts favouring write
// and only moves when update_en is high and a grant is actually made.
module jigsaw_rr_arb2 (
    input  logic aclk,
    input  logic aresetn,
    input  logic req_wr,
    input  logic req_rd,
    input  logic update_en,
    output logic grant_wr,
    output logic grant_rd
);

    logic last_wr;

    always_comb begin
        grant_wr = req_wr & (~req_rd | ~last_wr);
        grant_rd = req_rd & ~grant_wr;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_wr <= 1'b0;
        end else if (update_en && (grant_wr || grant_rd)) begin
            last_wr <= grant_wr;
        end
    end

endmodule

// File: rtl/jigsaw_mmio_req_sequencer.sv
// Services one device-side MMIO access per host go: arbitrate, issue a host
// descriptor, wait for its completion (or time out), then pulse clear/done.
//
// state | meaning
// IDLE  | waiting for go plus a valid requester
// ISSUE | descriptor presented on host_req until accepted
// WAIT  | counting down for the matching completion
// DONE  | one-cycle clear + done + requester ready pulse
// ERR   | one-cycle clear + requester ready pulse, request dropped
module jigsaw_mmio_req_sequencer
    import jigsaw_mmio_pkg::*;
#(
    parameter int VADDR_BITS     = 64,
    parameter int PID_BITS       = 6,
    parameter int OFFS_BITS      = 32,
    parameter int LEN_BITS       = 28,
    parameter int TIMEOUT_CYCLES = JIG_DEFAULT_TIMEOUT
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [VADDR_BITS-1:0] mmio_vaddr,
    input  logic                  mmio_ctrl,
    input  logic [PID_BITS-1:0]   coyote_pid,
    output logic                  mmio_clear,
    output logic                  mmio_write_done,
    output logic                  mmio_read_done,

    input  logic                  dev_wr_valid,
    output logic                  dev_wr_ready,
    input  logic [OFFS_BITS-1:0]  dev_wr_offset,
    input  logic [LEN_BITS-1:0]   dev_wr_len,

    input  logic                  dev_rd_valid,
    output logic                  dev_rd_ready,
    input  logic [OFFS_BITS-1:0]  dev_rd_offset,
    input  logic [LEN_BITS-1:0]   dev_rd_len,

    output logic                  host_req_valid,
    input  logic                  host_req_ready,
    output logic                  host_req_opcode,
    output logic [VADDR_BITS-1:0] host_req_vaddr,
    output logic [LEN_BITS-1:0]   host_req_len,
    output logic [PID_BITS-1:0]   host_req_pid,

    input  logic                  host_cpl_valid,
    input  logic                  host_cpl_opcode,

    output logic                  err_timeout
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    jig_state_e             state;
    logic [CNT_W-1:0]       tmo_cnt;
    logic                   arb_en;
    logic                   grant_wr;
    logic                   grant_rd;
    logic                   cpl_match;
    logic [VADDR_BITS-1:0]  wr_vaddr;
    logic [VADDR_BITS-1:0]  rd_vaddr;

    assign arb_en    = (state == IDLE) && mmio_ctrl;
    assign cpl_match = host_cpl_valid && (host_cpl_opcode == host_req_opcode);
    assign wr_vaddr  = mmio_vaddr + VADDR_BITS'(dev_wr_offset);
    assign rd_vaddr  = mmio_vaddr + VADDR_BITS'(dev_rd_offset);

    jigsaw_rr_arb2 u_arb (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_wr    (dev_wr_valid && arb_en),
        .req_rd    (dev_rd_valid && arb_en),
        .update_en (arb_en),
        .grant_wr  (grant_wr),
        .grant_rd  (grant_rd)
    );

    // The descriptor opcode register doubles as the latched opcode for
    // completion matching and for choosing which done/ready to pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            mmio_clear      <= 1'b0;
            mmio_write_done <= 1'b0;
            mmio_read_done  <= 1'b0;
            dev_wr_ready    <= 1'b0;
            dev_rd_ready    <= 1'b0;
            host_req_valid  <= 1'b0;
            host_req_opcode <= 1'b0;
            host_req_vaddr  <= '0;
            host_req_len    <= '0;
            host_req_pid    <= '0;
            err_timeout     <= 1'b0;
        end else begin
            mmio_clear      <= 1'b0;
            mmio_write_done <= 1'b0;
            mmio_read_done  <= 1'b0;
            dev_wr_ready    <= 1'b0;
            dev_rd_ready    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_wr || grant_rd) begin
                        host_req_valid  <= 1'b1;
                        host_req_opcode <= grant_wr ? JIG_OP_WR : JIG_OP_RD;
                        host_req_vaddr  <= grant_wr ? wr_vaddr : rd_vaddr;
                        host_req_len    <= grant_wr ? dev_wr_len : dev_rd_len;
                        host_req_pid    <= coyote_pid;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (host_req_ready) begin
                        host_req_valid <= 1'b0;
                        tmo_cnt        <= TMO_LOAD;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // A match on the terminal count still wins over the timeout.
                    if (cpl_match) begin
                        mmio_clear      <= 1'b1;
                        mmio_write_done <= (host_req_opcode == JIG_OP_WR);
                        mmio_read_done  <= (host_req_opcode == JIG_OP_RD);
                        dev_wr_ready    <= (host_req_opcode == JIG_OP_WR);
                        dev_rd_ready    <= (host_req_opcode == JIG_OP_RD);
                        state           <= DONE;
                    end else if (tmo_cnt == '0) begin
                        mmio_clear   <= 1'b1;
                        dev_wr_ready <= (host_req_opcode == JIG_OP_WR);
                        dev_rd_ready <= (host_req_opcode == JIG_OP_RD);
                        err_timeout  <= 1'b1;
                        state        <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jigsaw_mmio_req_sequencer.sv
// Directed bench for jigsaw_mmio_req_sequencer with hand-computed expectations.
module tb_jigsaw_mmio_req_sequencer;

    logic        aclk;
    logic        aresetn;
    logic [63:0] mmio_vaddr;
    logic        mmio_ctrl;
    logic [5:0]  coyote_pid;
    logic        mmio_clear;
    logic        mmio_write_done;
    logic        mmio_read_done;
    logic        dev_wr_valid;
    logic        dev_wr_ready;
    logic [31:0] dev_wr_offset;
    logic [27:0] dev_wr_len;
    logic        dev_rd_valid;
    logic        dev_rd_ready;
    logic [31:0] dev_rd_offset;
    logic [27:0] dev_rd_len;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_opcode;
    logic [63:0] host_req_vaddr;
    logic [27:0] host_req_len;
    logic [5:0]  host_req_pid;
    logic        host_cpl_valid;
    logic        host_cpl_opcode;
    logic        err_timeout;

    int          vectors;
    int          miscompares;
    logic [5:0]  exp_pid;
    bit          ok;

    jigsaw_mmio_req_sequencer #(
        .VADDR_BITS     (64),
        .PID_BITS       (6),
        .OFFS_BITS      (32),
        .LEN_BITS       (28),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .mmio_vaddr      (mmio_vaddr),
        .mmio_ctrl       (mmio_ctrl),
        .coyote_pid      (coyote_pid),
        .mmio_clear      (mmio_clear),
        .mmio_write_done (mmio_write_done),
        .mmio_read_done  (mmio_read_done),
        .dev_wr_valid    (dev_wr_valid),
        .dev_wr_ready    (dev_wr_ready),
        .dev_wr_offset   (dev_wr_offset),
        .dev_wr_len      (dev_wr_len),
        .dev_rd_valid    (dev_rd_valid),
        .dev_rd_ready    (dev_rd_ready),
        .dev_rd_offset   (dev_rd_offset),
        .dev_rd_len      (dev_rd_len),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_opcode (host_req_opcode),
        .host_req_vaddr  (host_req_vaddr),
        .host_req_len    (host_req_len),
        .host_req_pid    (host_req_pid),
        .host_cpl_valid  (host_cpl_valid),
        .host_cpl_opcode (host_cpl_opcode),
        .err_timeout     (err_timeout)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One go with immediate handshake; completion after cpl_wait WAIT cycles.
    task automatic access(input string tag, input logic exp_op, input logic [63:0] exp_va,
                          input logic [27:0] exp_len, input int cpl_wait);
        mmio_ctrl = 1'b1;
        tick();
        chk({tag, "_req_valid"}, 64'(host_req_valid), 64'(1));
        chk({tag, "_opcode"}, 64'(host_req_opcode), 64'(exp_op));
        chk({tag, "_vaddr"}, host_req_vaddr, exp_va);
        chk({tag, "_len"}, 64'(host_req_len), 64'(exp_len));
        chk({tag, "_pid"}, 64'(host_req_pid), 64'(exp_pid));
        host_req_ready = 1'b1;
        tick();
        host_req_ready = 1'b0;
        chk({tag, "_req_dropped"}, 64'(host_req_valid), 64'(0));
        repeat (cpl_wait) tick();
        host_cpl_valid  = 1'b1;
        host_cpl_opcode = exp_op;
        tick();
        host_cpl_valid  = 1'b0;
        chk({tag, "_clear"}, 64'(mmio_clear), 64'(1));
        chk({tag, "_wdone"}, 64'(mmio_write_done), 64'(exp_op));
        chk({tag, "_rdone"}, 64'(mmio_read_done), 64'(!exp_op));
        chk({tag, "_wr_ready"}, 64'(dev_wr_ready), 64'(exp_op));
        chk({tag, "_rd_ready"}, 64'(dev_rd_ready), 64'(!exp_op));
        mmio_ctrl = 1'b0;
        tick();
        chk({tag, "_clear_end"}, 64'(mmio_clear), 64'(0));
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        aresetn         = 1'b0;
        mmio_vaddr      = '0;
        mmio_ctrl       = 1'b0;
        coyote_pid      = 6'h2A;
        exp_pid         = 6'h2A;
        dev_wr_valid    = 1'b0;
        dev_wr_offset   = '0;
        dev_wr_len      = '0;
        dev_rd_valid    = 1'b0;
        dev_rd_offset   = '0;
        dev_rd_len      = '0;
        host_req_ready  = 1'b0;
        host_cpl_valid  = 1'b0;
        host_cpl_opcode = 1'b0;

        repeat (2) tick();
        chk("rst_req_valid", 64'(host_req_valid), 64'(0));
        chk("rst_clear", 64'(mmio_clear), 64'(0));
        chk("rst_dones", 64'({mmio_write_done, mmio_read_done}), 64'(0));
        chk("rst_readies", 64'({dev_wr_ready, dev_rd_ready}), 64'(0));
        chk("rst_err", 64'(err_timeout), 64'(0));
        aresetn = 1'b1;
        tick();

        // Single write access, then no second request while go is low.
        mmio_vaddr    = 64'h1000;
        dev_wr_valid  = 1'b1;
        dev_wr_offset = 32'h20;
        dev_wr_len    = 28'd64;
        access("t1", 1'b1, 64'h1020, 28'd64, 5);
        ok = 1'b1;
        repeat (3) begin
            tick();
            ok = ok && (host_req_valid === 1'b0) && (mmio_write_done === 1'b0) && (mmio_clear === 1'b0);
        end
        chk("t1_no_retrigger", 64'(ok), 64'(1));
        dev_wr_valid = 1'b0;

        // Read with back-pressured descriptor, go dropped after grant, mismatched completion.
        mmio_vaddr    = 64'h2000;
        dev_rd_valid  = 1'b1;
        dev_rd_offset = 32'h40;
        dev_rd_len    = 28'd16;
        mmio_ctrl     = 1'b1;
        tick();
        mmio_ctrl = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            ok = ok && (host_req_valid === 1'b1) && (host_req_vaddr === 64'h2040)
                    && (host_req_len === 28'd16) && (host_req_opcode === 1'b0);
            tick();
        end
        chk("t3_stable", 64'(ok), 64'(1));
        chk("t3_still_valid", 64'(host_req_valid), 64'(1));
        host_req_ready = 1'b1;
        tick();
        host_req_ready  = 1'b0;
        host_cpl_valid  = 1'b1;
        host_cpl_opcode = 1'b1;
        tick();
        host_cpl_valid = 1'b0;
        chk("t3_mismatch_clear", 64'(mmio_clear), 64'(0));
        chk("t3_mismatch_rdone", 64'(mmio_read_done), 64'(0));
        tick();
        host_cpl_valid  = 1'b1;
        host_cpl_opcode = 1'b0;
        tick();
        host_cpl_valid = 1'b0;
        chk("t3_rdone", 64'(mmio_read_done), 64'(1));
        chk("t3_clear", 64'(mmio_clear), 64'(1));
        chk("t3_rd_ready", 64'(dev_rd_ready), 64'(1));
        chk("t3_wdone", 64'(mmio_write_done), 64'(0));
        dev_rd_valid = 1'b0;
        tick();
        chk("t3_rdone_end", 64'(mmio_read_done), 64'(0));

        // Both valid across three gos: last grant was read, so W, R, W.
        mmio_vaddr    = 64'h1000;
        dev_wr_valid  = 1'b1;
        dev_wr_offset = 32'h10;
        dev_wr_len    = 28'd8;
        dev_rd_valid  = 1'b1;
        dev_rd_offset = 32'h30;
        dev_rd_len    = 28'd12;
        access("t2a", 1'b1, 64'h1010, 28'd8, 0);
        access("t2b", 1'b0, 64'h1030, 28'd12, 0);
        access("t2c", 1'b1, 64'h1010, 28'd8, 0);
        dev_wr_valid = 1'b0;
        dev_rd_valid = 1'b0;

        // Timeout: ERR visible 16 edges after the handshake edge.
        dev_wr_valid  = 1'b1;
        dev_wr_offset = 32'h0;
        dev_wr_len    = 28'd4;
        mmio_ctrl     = 1'b1;
        tick();
        host_req_ready = 1'b1;
        tick();
        host_req_ready = 1'b0;
        ok = 1'b1;
        repeat (15) begin
            tick();
            ok = ok && (err_timeout === 1'b0) && (mmio_clear === 1'b0);
        end
        chk("t4_no_early_err", 64'(ok), 64'(1));
        tick();
        chk("t4_err", 64'(err_timeout), 64'(1));
        chk("t4_clear", 64'(mmio_clear), 64'(1));
        chk("t4_dones", 64'({mmio_write_done, mmio_read_done}), 64'(0));
        chk("t4_wr_ready", 64'(dev_wr_ready), 64'(1));
        mmio_ctrl    = 1'b0;
        dev_wr_valid = 1'b0;
        tick();
        chk("t4_clear_end", 64'(mmio_clear), 64'(0));
        chk("t4_err_sticky", 64'(err_timeout), 64'(1));

        // Address wrap, with a new pid.
        coyote_pid    = 6'h15;
        exp_pid       = 6'h15;
        mmio_vaddr    = 64'hFFFF_FFFF_FFFF_FFFC;
        dev_wr_valid  = 1'b1;
        dev_wr_offset = 32'h8;
        dev_wr_len    = 28'd4;
        access("t5", 1'b1, 64'h4, 28'd4, 1);
        dev_wr_valid = 1'b0;

        // Asynchronous reset while in WAIT, then a fresh read.
        mmio_vaddr    = 64'h3000;
        dev_rd_valid  = 1'b1;
        dev_rd_offset = 32'h8;
        dev_rd_len    = 28'd32;
        mmio_ctrl     = 1'b1;
        tick();
        host_req_ready = 1'b1;
        tick();
        host_req_ready = 1'b0;
        mmio_ctrl      = 1'b0;
        tick();
        aresetn = 1'b0;
        #1;
        chk("t6_async_err", 64'(err_timeout), 64'(0));
        chk("t6_async_vaddr", host_req_vaddr, 64'h0);
        chk("t6_async_opcode", 64'(host_req_opcode), 64'(0));
        host_cpl_valid  = 1'b1;
        host_cpl_opcode = 1'b0;
        tick();
        host_cpl_valid = 1'b0;
        tick();
        chk("t6_in_reset_pulses", 64'({mmio_clear, mmio_read_done, dev_rd_ready}), 64'(0));
        aresetn = 1'b1;
        tick();
        chk("t6_post_rst_idle", 64'({host_req_valid, mmio_clear, mmio_read_done}), 64'(0));
        access("t6", 1'b0, 64'h3008, 28'd32, 1);
        dev_rd_valid = 1'b0;
        tick();
        chk("t6_err_clear", 64'(err_timeout), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
